// File: rtl/df_merge_rr.sv
// Round-robin, tensor-granular merge of NUM_IN valid/ready producers onto one consumer.
// Arbitration is registered (one IDLE bubble per tensor); the beat data path is a pure mux.
module df_merge_rr #(
  parameter  int NUM_IN            = 2,
  parameter  int DATA_PRECISION_0  = 16,
  parameter  int DATA_PRECISION_1  = 3,
  parameter  int TENSOR_SIZE_DIM_0 = 4,
  parameter  int TENSOR_SIZE_DIM_1 = 1,
  parameter  int PARALLELISM_DIM_0 = 4,
  parameter  int PARALLELISM_DIM_1 = 1,
  localparam int PAR               = PARALLELISM_DIM_0 * PARALLELISM_DIM_1,
  localparam int BEATS_PER_TENSOR  = (TENSOR_SIZE_DIM_0 / PARALLELISM_DIM_0) *
                                     (TENSOR_SIZE_DIM_1 / PARALLELISM_DIM_1),
  localparam int ID_W              = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [DATA_PRECISION_0-1:0] data_in [NUM_IN*PAR],
  input  logic [NUM_IN-1:0]           data_in_valid,
  output logic [NUM_IN-1:0]           data_in_ready,
  output logic [DATA_PRECISION_0-1:0] data_out [PAR],
  output logic                        data_out_valid,
  input  logic                        data_out_ready,
  output logic [ID_W-1:0]             grant_id,
  output logic                        busy
);

  // state  | meaning
  // IDLE   | no grant held; arbitrate among valid requesters this cycle
  // LOCKED | grant_id owns the consumer until BEATS_PER_TENSOR fires
  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] LOCKED = 1'b1;

  localparam int              CNT_W     = $clog2(BEATS_PER_TENSOR) + 1;
  localparam int              SUM_W     = ID_W + 1;
  localparam logic [ID_W-1:0] LAST_ID   = ID_W'(NUM_IN - 1);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS_PER_TENSOR - 1);

  if (NUM_IN < 1 || BEATS_PER_TENSOR < 1 || DATA_PRECISION_1 > DATA_PRECISION_0) begin : g_bad_cfg
    $error("df_merge_rr: invalid parameterisation");
  end

  logic [0:0]       state;
  logic [ID_W-1:0]  rr_ptr;
  logic [CNT_W-1:0] beat_cnt;
  logic [ID_W-1:0]  pick_idx;
  logic             pick_found;
  logic [SUM_W-1:0] cand_sum;
  logic             fire;

  // Circular first-set search starting at rr_ptr; operands stay below NUM_IN so one subtract wraps.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = rr_ptr;
    cand_sum   = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      cand_sum = {1'b0, rr_ptr} + SUM_W'(k);
      if (cand_sum >= SUM_W'(NUM_IN)) cand_sum = cand_sum - SUM_W'(NUM_IN);
      if (!pick_found && data_in_valid[cand_sum[ID_W-1:0]]) begin
        pick_found = 1'b1;
        pick_idx   = cand_sum[ID_W-1:0];
      end
    end
  end

  assign busy           = (state == LOCKED);
  assign data_out_valid = busy && data_in_valid[grant_id];
  assign fire           = data_out_valid && data_out_ready;

  always_comb begin
    data_in_ready = '0;
    if (busy) data_in_ready[grant_id] = data_out_ready;
  end

  // grant_id is 0 out of reset, so the idle output shows requester 0 rather than X.
  always_comb begin
    for (int j = 0; j < PAR; j++) data_out[j] = data_in[j];
    for (int i = 1; i < NUM_IN; i++) begin
      if (grant_id == ID_W'(i)) begin
        for (int j = 0; j < PAR; j++) data_out[j] = data_in[i*PAR + j];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      beat_cnt <= '0;
      grant_id <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_found) begin
            grant_id <= pick_idx;
            state    <= LOCKED;
          end
        end
        LOCKED: begin
          if (fire) begin
            if (beat_cnt == LAST_BEAT) begin
              beat_cnt <= '0;
              rr_ptr   <= (grant_id == LAST_ID) ? '0 : grant_id + 1'b1;
              state    <= IDLE;
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_df_merge_rr.sv
// Bench for df_merge_rr: a default instance (2 requesters, 1 beat/tensor) and a
// 3-requester, 4-beat instance checked through an expected-beat queue.
module tb_df_merge_rr;

  logic clk;
  logic rst;

  // instance A: defaults
  logic [15:0] din_a [8];
  logic [1:0]  vld_a;
  logic [1:0]  rdy_a;
  logic [15:0] dout_a [4];
  logic        dv_a;
  logic        ordy_a;
  logic [0:0]  gid_a;
  logic        busy_a;

  // instance B: NUM_IN=3, BEATS_PER_TENSOR=4
  logic [15:0] din_b [12];
  logic [2:0]  vld_b;
  logic [2:0]  rdy_b;
  logic [15:0] dout_b [4];
  logic        dv_b;
  logic        ordy_b;
  logic [1:0]  gid_b;
  logic        busy_b;

  df_merge_rr u_a (
    .clk(clk), .rst(rst), .data_in(din_a), .data_in_valid(vld_a), .data_in_ready(rdy_a),
    .data_out(dout_a), .data_out_valid(dv_a), .data_out_ready(ordy_a),
    .grant_id(gid_a), .busy(busy_a)
  );

  df_merge_rr #(.NUM_IN(3), .TENSOR_SIZE_DIM_0(16)) u_b (
    .clk(clk), .rst(rst), .data_in(din_b), .data_in_valid(vld_b), .data_in_ready(rdy_b),
    .data_out(dout_b), .data_out_valid(dv_b), .data_out_ready(ordy_b),
    .grant_id(gid_b), .busy(busy_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct { int id; int beat; } exp_t;
  exp_t q_b[$];
  exp_t e;
  int   src_b [3];
  logic [2:0] hs_b;
  logic ok;

  function automatic int expv(int r, int beat, int el);
    return r * 256 + beat * 16 + el;
  endfunction

  always_comb begin
    for (int i = 0; i < 8; i++) din_a[i] = 16'((i / 4) * 16 + (i % 4));
    for (int r = 0; r < 3; r++)
      for (int el = 0; el < 4; el++) din_b[r*4 + el] = 16'(expv(r, src_b[r], el));
  end

  task automatic chk(input string name, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp_v, $time);
    end
  endtask

  task automatic push(input int id, input int b0, input int n);
    for (int k = 0; k < n; k++) q_b.push_back('{id: id, beat: b0 + k});
  endtask

  task automatic drain(input int bound);
    int n;
    n = 0;
    while (q_b.size() != 0 && n < bound) begin
      @(posedge clk); #1;
      n++;
    end
    if (q_b.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout: %0d beats still expected", q_b.size());
      q_b.delete();
    end
  endtask

  // Producers advance to their next beat after every accepted handshake.
  initial begin
    for (int r = 0; r < 3; r++) src_b[r] = 0;
    forever begin
      @(posedge clk); #1;
      for (int r = 0; r < 3; r++) if (hs_b[r]) src_b[r] = src_b[r] + 1;
    end
  end

  // Monitor: pops the expected beat on each output fire of instance B.
  always @(negedge clk) begin
    hs_b = rst ? (vld_b & rdy_b) : 3'b000;
    if (rst) begin
      if (busy_b) chk("other_ready_zero", int'(rdy_b & ~(3'b001 << gid_b)), 0);
      if (dv_b && ordy_b) begin
        if (q_b.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_beat: grant=%0d data0=%0d", gid_b, dout_b[0]);
        end else begin
          e  = q_b.pop_front();
          ok = (int'(gid_b) == e.id);
          for (int el = 0; el < 4; el++) if (int'(dout_b[el]) != expv(e.id, e.beat, el)) ok = 1'b0;
          checks++;
          if (!ok) begin
            errors++;
            $display("FAIL beat: got grant=%0d data0=%0d expected grant=%0d data0=%0d",
                     gid_b, dout_b[0], e.id, expv(e.id, e.beat, 0));
          end
        end
      end
    end
  end

  int fires, gap;
  logic gap_done;

  initial begin
    rst = 1'b0; vld_a = '0; ordy_a = 1'b0; vld_b = '0; ordy_b = 1'b0;

    // 1: reset then idle
    for (int c = 0; c < 6; c++) begin
      if (c == 3) begin @(posedge clk); #1; rst = 1'b1; end
      @(negedge clk);
      chk("rst_busy", int'({busy_a, busy_b}), 0);
      chk("rst_valid", int'({dv_a, dv_b}), 0);
      chk("rst_ready", int'({rdy_a, rdy_b}), 0);
      chk("rst_grant", int'({gid_a, gid_b}), 0);
    end

    // 2: single requester, 1 beat per tensor -> valid 0,1,0,1
    @(posedge clk); #1;
    vld_a = 2'b10; ordy_a = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("a_valid_pattern", int'(dv_a), k % 2);
      if (k % 2 == 1) begin
        chk("a_grant", int'(gid_a), 1);
        chk("a_ready", int'(rdy_a), 2);
        for (int el = 0; el < 4; el++) chk("a_data", int'(dout_a[el]), 16 + el);
      end
      @(posedge clk); #1;
    end
    vld_a = '0;

    // 3: round-robin with all three requesting
    push(0, 0, 4); push(1, 0, 4); push(2, 0, 4); push(0, 4, 4);
    vld_b = 3'b111; ordy_b = 1'b1;
    drain(60);
    vld_b = '0;
    @(negedge clk);
    chk("rr_idle_after", int'(busy_b), 0);

    // 4: backpressure toggling and a 2-cycle valid gap on the granted requester
    @(posedge clk); #1;
    push(1, 4, 4); push(2, 4, 4);
    vld_b = 3'b110; ordy_b = 1'b1;
    fires = 0; gap = 0; gap_done = 1'b0;
    for (int c = 0; c < 40 && fires < 4; c++) begin
      @(negedge clk);
      if (busy_b) begin
        chk("bp_grant_held", int'(gid_b), 1);
        chk("bp_beat_cnt", int'(u_b.beat_cnt), fires);
        if (!vld_b[1]) chk("bp_valid_follows", int'(dv_b), 0);
      end
      if (vld_b[1] && rdy_b[1]) fires++;
      if (fires < 4) begin
        @(posedge clk); #1;
        ordy_b = ~ordy_b;
        if (fires == 2 && !gap_done) begin
          if (gap < 2) begin vld_b[1] = 1'b0; gap++; end
          else begin vld_b[1] = 1'b1; gap_done = 1'b1; end
        end
      end
    end
    chk("bp_fires", fires, 4);
    @(posedge clk); #1;
    ordy_b = 1'b1;
    @(negedge clk);
    chk("bp_idle_after_4th", int'(busy_b), 0);
    chk("bp_cnt_cleared", int'(u_b.beat_cnt), 0);
    drain(40);
    vld_b = '0;

    // 5: req1 raises valid in the cycle of req0's final beat
    @(posedge clk); #1;
    push(0, 8, 4); push(1, 8, 4);
    vld_b = 3'b001;
    fires = 0;
    for (int c = 0; c < 20 && fires < 3; c++) begin
      @(negedge clk);
      if (vld_b[0] && rdy_b[0]) fires++;
    end
    chk("sim_pre_fires", fires, 3);
    @(posedge clk); #1;
    vld_b = 3'b011;
    @(negedge clk);
    chk("sim_last_beat_busy", int'(busy_b), 1);
    chk("sim_last_beat_grant", int'(gid_b), 0);
    chk("sim_last_beat_cnt", int'(u_b.beat_cnt), 3);
    @(posedge clk); #1;
    vld_b = 3'b010;
    @(negedge clk);
    chk("sim_bubble", int'(busy_b), 0);
    @(negedge clk);
    chk("sim_next_busy", int'(busy_b), 1);
    chk("sim_next_grant", int'(gid_b), 1);
    drain(30);
    vld_b = '0;

    // 6: reset in the middle of a tensor
    @(posedge clk); #1;
    push(1, 12, 2);
    vld_b = 3'b010;
    fires = 0;
    for (int c = 0; c < 20 && fires < 2; c++) begin
      @(negedge clk);
      if (vld_b[1] && rdy_b[1]) fires++;
    end
    chk("mid_pre_fires", fires, 2);
    @(posedge clk); #1;
    chk("mid_cnt_before_rst", int'(u_b.beat_cnt), 2);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_busy", int'(busy_b), 0);
    chk("mid_rst_valid", int'(dv_b), 0);
    chk("mid_rst_ready", int'(rdy_b), 0);
    chk("mid_rst_cnt", int'(u_b.beat_cnt), 0);
    vld_b = 3'b011;
    push(0, 12, 4);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("mid_post_idle", int'(busy_b), 0);
    @(negedge clk);
    chk("mid_post_grant", int'(gid_b), 0);
    chk("mid_post_cnt", int'(u_b.beat_cnt), 0);
    drain(30);
    vld_b = '0;

    repeat (3) @(posedge clk);
    chk("queue_empty", q_b.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
